// File: rtl/cpu_types_pkg.sv
// Shared CPU type package.
// Provides the RAM-facing word and status types together with the RAM
// arbiter's state type, starvation limit, and an index-width helper.
// Ports: none (package).

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Lost arbitrations after which an even (icache) requester is forced to win.
  localparam logic [2:0] ARB_STARVE_MAX = 3'd7;

  // Width of an index into n items. It never returns 0, so a one-member
  // class still gets a legal one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter.
// There is one lane per requester. The master modport is the requester
// (cache/coherence) side. The slave modport is the arbiter.
//   req/wen/blk  per-requester request, write flag, and block-transfer flag
//   addr/wdata   per-requester word address and store data
//   rwait        active-low per-beat acknowledge
//   rerr         one-cycle error pulse to the owner
//   rdata        RAM load data broadcast to every requester

interface ram_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 4
);

  logic  [NREQ-1:0] req;
  logic  [NREQ-1:0] wen;
  logic  [NREQ-1:0] blk;
  word_t [NREQ-1:0] addr;
  word_t [NREQ-1:0] wdata;
  logic  [NREQ-1:0] rwait;
  logic  [NREQ-1:0] rerr;
  word_t            rdata;

  modport master (
    output req, wen, blk, addr, wdata,
    input  rwait, rerr, rdata
  );

  modport slave (
    input  req, wen, blk, addr, wdata,
    output rwait, rerr, rdata
  );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// It scans req starting at ptr, moving upward and wrapping from N-1 to 0.
// The first set bit wins.
//   req    request vector
//   ptr    scan start index (must be < N)
//   grant  one-hot grant (all zero when nothing is requested)
//   idx    index of the granted bit
//   valid  at least one request is set

module rr_pick
  import cpu_types_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = W'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin owner of the single-ported RAM.
// An owner is held for a whole block transfer, so cache fills and writebacks
// never interleave. Picking a new owner costs one IDLE cycle.
// Optional feature: when ARB_DATA_PRIORITY_EN is defined, odd (dcache)
// requesters beat even (icache) ones. Round-robin still applies within each
// class. An even requester that has lost ARB_STARVE_MAX arbitrations is then
// forced to win once.
// Ports:
//   CLK, nRST           clock and asynchronous active-low reset
//   bus (slave)         per-requester req/wen/blk/addr/wdata in; rwait/rerr/rdata out
//   owner               current owner index
//   busy                high while a transfer is in progress
//   ramREN/ramWEN       RAM read/write enables
//   ramaddr/ramstore    RAM address and store data
//   ramstate/ramload    RAM status and load data

module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter  int NREQ        = 4,
  parameter  int BLOCK_WORDS = 2,
  localparam int IDX_W       = $clog2(NREQ)
) (
  input  logic             CLK,
  input  logic             nRST,
  ram_arbiter_if.slave     bus,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             ramREN,
  output logic             ramWEN,
  output word_t            ramaddr,
  output word_t            ramstore,
  input  ramstate_t        ramstate,
  input  word_t            ramload
);

  localparam logic [1:0]       LAST_BLK = 2'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]       beat_q, beat_d;
  logic             wen_q, wen_d;
  logic             blk_q, blk_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_grant;
  logic [IDX_W-1:0] next_ptr;
  logic [1:0]       last_beat;
  logic [NREQ-1:0]  rwait_c, rerr_c;

  // After any exit from XFER, the finishing owner drops to the lowest priority.
  assign next_ptr  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign last_beat = blk_q ? LAST_BLK : 2'd0;

`ifdef ARB_DATA_PRIORITY_EN
  localparam int NODD  = NREQ / 2;
  localparam int NEVEN = NREQ - NODD;
  localparam int OW    = idx_width(NODD);
  localparam int EW    = idx_width(NEVEN);

  logic [NODD-1:0]  odd_req, odd_grant;
  logic [NEVEN-1:0] even_req, even_in, even_grant, starving;
  logic [OW-1:0]    odd_ptr, odd_idx;
  logic [EW-1:0]    even_ptr, even_idx;
  logic             odd_valid, even_valid, use_odd, arbitrate;
  logic [2:0]       starve_q [NEVEN];

  always_comb begin
    for (int k = 0; k < NODD; k++) odd_req[k] = bus.req[2*k+1];
    for (int k = 0; k < NEVEN; k++) begin
      even_req[k] = bus.req[2*k];
      starving[k] = bus.req[2*k] && (starve_q[k] == ARB_STARVE_MAX);
    end
  end

  // Convert the global pointer into each class: start from the first class
  // member whose global index is >= rr_ptr, wrapping to 0 past the end.
  always_comb begin
    int op, ep;
    op = int'(rr_ptr_q) >> 1;
    ep = (int'(rr_ptr_q) + 1) >> 1;
    if (op >= NODD)  op = 0;
    if (ep >= NEVEN) ep = 0;
    odd_ptr  = OW'(op);
    even_ptr = EW'(ep);
  end

  // While any even requester is starving, only those requesters compete.
  assign even_in = (|starving) ? starving : even_req;
  assign use_odd = odd_valid && !(|starving);

  rr_pick #(.N(NODD)) u_pick_odd (
    .req(odd_req), .ptr(odd_ptr), .grant(odd_grant), .idx(odd_idx), .valid(odd_valid)
  );

  rr_pick #(.N(NEVEN)) u_pick_even (
    .req(even_in), .ptr(even_ptr), .grant(even_grant), .idx(even_idx), .valid(even_valid)
  );

  assign pick_valid = odd_valid || even_valid;
  assign pick_idx   = use_odd ? IDX_W'({odd_idx, 1'b1}) : IDX_W'({even_idx, 1'b0});

  always_comb begin
    pick_grant = '0;
    for (int k = 0; k < NODD; k++)  pick_grant[2*k+1] = use_odd && odd_grant[k];
    for (int k = 0; k < NEVEN; k++) pick_grant[2*k]   = !use_odd && even_grant[k];
  end

  assign arbitrate = (state_q == IDLE) && pick_valid;

  // NOTE: the starvation counters are a handful of flops, not a RAM array,
  // so they take the async reset like any other state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < NEVEN; k++) starve_q[k] <= '0;
    end else if (arbitrate) begin
      for (int k = 0; k < NEVEN; k++) begin
        if (pick_grant[2*k])
          starve_q[k] <= '0;
        else if (bus.req[2*k] && (starve_q[k] != ARB_STARVE_MAX))
          starve_q[k] <= starve_q[k] + 3'd1;
      end
    end
  end
`else
  rr_pick #(.N(NREQ)) u_pick (
    .req(bus.req), .ptr(rr_ptr_q), .grant(pick_grant), .idx(pick_idx), .valid(pick_valid)
  );
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    wen_d    = wen_q;
    blk_d    = blk_q;
    rwait_c  = '1;
    rerr_c   = '0;
    busy     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = bus.addr[owner_q];
    ramstore = bus.wdata[owner_q];

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = XFER;
          owner_d = pick_idx;
          beat_d  = '0;
          wen_d   = |(bus.wen & pick_grant);
          blk_d   = |(bus.blk & pick_grant);
        end
      end
      XFER: begin
        busy = 1'b1;
        if (!bus.req[owner_q]) begin
          // The owner withdrew: enables drop now, and no ack is given.
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          ramWEN = wen_q;
          ramREN = !wen_q;
          case (ramstate)
            ACCESS: begin
              rwait_c[owner_q] = 1'b0;
              if (beat_q == last_beat) begin
                state_d  = IDLE;
                rr_ptr_d = next_ptr;
              end else begin
                beat_d = beat_q + 2'd1;
              end
            end
            ERROR: begin
              rerr_c[owner_q] = 1'b1;
              state_d         = IDLE;
              rr_ptr_d        = next_ptr;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      wen_q    <= 1'b0;
      blk_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so all registers update together
      // from values computed in the previous cycle.
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      wen_q    <= wen_d;
      blk_q    <= blk_d;
    end
  end

  assign owner     = owner_q;
  assign bus.rwait = rwait_c;
  assign bus.rerr  = rerr_c;
  assign bus.rdata = ramload;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter (NREQ=4, BLOCK_WORDS=2).
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later,
// well away from the rising edge.
// Expected grant orders follow ARB_DATA_PRIORITY_EN when that macro is defined.

module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 4;

  logic       CLK, nRST;
  logic [1:0] owner;
  logic       busy, ramREN, ramWEN;
  word_t      ramaddr, ramstore, ramload;
  ramstate_t  ramstate;

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter_if #(.NREQ(NREQ)) bus ();

  ram_arbiter #(.NREQ(NREQ), .BLOCK_WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .owner(owner), .busy(busy),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramstate(ramstate), .ramload(ramload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic do_reset();
    bus.req = '0; bus.wen = '0; bus.blk = '0;
    ramstate = FREE;
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = 4'b1111; bus.blk = 4'b1111; ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    nRST = 1'b0;
    #1;
    n_tests++;
    if ({busy, ramREN, ramWEN, bus.rwait, bus.rerr} !== 11'b000_1111_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", {busy, ramREN, ramWEN, bus.rwait, bus.rerr}, 11'b000_1111_0000);
    end
    n_tests++;
    if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    n_tests++;
    if (bus.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdata_a: got %h expected deadbeef", bus.rdata); end
    @(negedge CLK);
    ramload = 32'h1234_5678;
    #1;
    n_tests++;
    if ({busy, ramREN} !== 2'b00) begin n_fail++; $display("FAIL reset_held: got %b expected 00", {busy, ramREN}); end
    n_tests++;
    if (bus.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rdata_b: got %h expected 12345678", bus.rdata); end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001; bus.addr[0] = 32'h40; ramstate = FREE;
    #1;
    n_tests++;
    if ({busy, ramREN, ramWEN} !== 3'b000) begin n_fail++; $display("FAIL single_idle: got %b expected 000", {busy, ramREN, ramWEN}); end
    @(negedge CLK); ramstate = BUSY; #1;
    n_tests++;
    if ({owner, busy, ramREN, ramWEN, bus.rwait} !== {2'd0, 3'b110, 4'b1111}) begin
      n_fail++; $display("FAIL single_busy: got %b expected %b", {owner, busy, ramREN, ramWEN, bus.rwait}, {2'd0, 3'b110, 4'b1111});
    end
    n_tests++;
    if (ramaddr !== 32'h40) begin n_fail++; $display("FAIL single_addr: got %h expected 00000040", ramaddr); end
    @(negedge CLK); ramstate = ACCESS; #1;
    n_tests++;
    if (bus.rwait !== 4'b1110) begin n_fail++; $display("FAIL single_ack: got %b expected 1110", bus.rwait); end
    @(negedge CLK); ramstate = FREE; bus.req = 4'b0011; #1;
    n_tests++;
    if ({busy, bus.rwait} !== 5'b0_1111) begin n_fail++; $display("FAIL single_back_idle: got %b expected 01111", {busy, bus.rwait}); end
    @(negedge CLK); #1;
    n_tests++;
    if ({owner, busy} !== {2'd1, 1'b1}) begin n_fail++; $display("FAIL single_next_owner: got %b expected 011", {owner, busy}); end
  endtask

  task automatic test_round_robin();
    int         exp_o [5];
    logic [3:0] oh;
`ifdef ARB_DATA_PRIORITY_EN
    exp_o = '{1, 3, 1, 3, 1};
`else
    exp_o = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    bus.req = 4'b1111; bus.blk = 4'b1111; bus.wen = 4'b0000; ramstate = ACCESS;
    for (int g = 0; g < 5; g++) begin
      if (g != 0) @(negedge CLK);
      #1;
      n_tests++;
      if ({busy, bus.rwait} !== 5'b0_1111) begin
        n_fail++; $display("FAIL rr_gap%0d: got %b expected 01111", g, {busy, bus.rwait});
      end
      oh = 4'b0001 << exp_o[g];
      for (int b = 0; b < 2; b++) begin
        @(negedge CLK); #1;
        n_tests++;
        if ({owner, busy, bus.rwait} !== {2'(exp_o[g]), 1'b1, ~oh}) begin
          n_fail++; $display("FAIL rr_grant%0d_beat%0d: got %b expected %b", g, b, {owner, busy, bus.rwait}, {2'(exp_o[g]), 1'b1, ~oh});
        end
      end
    end
  endtask

  task automatic test_write_block();
    int acks = 0;
    do_reset();
    bus.req = 4'b0100; bus.wen = 4'b0100; bus.blk = 4'b0100;
    bus.addr[2] = 32'h100; bus.wdata[2] = 32'hAAAA_0000; ramstate = FREE;
    @(negedge CLK); ramstate = BUSY; #1;
    if (bus.rwait[2] == 1'b0) acks++;
    n_tests++;
    if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h100, 32'hAAAA_0000}) begin
      n_fail++; $display("FAIL wr_setup: got %b %h %h expected 10 00000100 aaaa0000", {ramWEN, ramREN}, ramaddr, ramstore);
    end
    @(negedge CLK); ramstate = ACCESS; #1;
    if (bus.rwait[2] == 1'b0) acks++;
    n_tests++;
    if ({bus.rwait, ramWEN, ramaddr, ramstore} !== {4'b1011, 1'b1, 32'h100, 32'hAAAA_0000}) begin
      n_fail++; $display("FAIL wr_beat0: got %b %b %h %h expected 1011 1 00000100 aaaa0000", bus.rwait, ramWEN, ramaddr, ramstore);
    end
    @(negedge CLK); bus.addr[2] = 32'h104; bus.wdata[2] = 32'hBBBB_0000; #1;
    if (bus.rwait[2] == 1'b0) acks++;
    n_tests++;
    if ({bus.rwait, ramWEN, ramaddr, ramstore} !== {4'b1011, 1'b1, 32'h104, 32'hBBBB_0000}) begin
      n_fail++; $display("FAIL wr_beat1: got %b %b %h %h expected 1011 1 00000104 bbbb0000", bus.rwait, ramWEN, ramaddr, ramstore);
    end
    @(negedge CLK); bus.req = 4'b0000; ramstate = FREE; #1;
    if (bus.rwait[2] == 1'b0) acks++;
    n_tests++;
    if ({busy, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL wr_done: got %b expected 00", {busy, ramWEN}); end
    n_tests++;
    if (acks !== 2) begin n_fail++; $display("FAIL wr_ack_count: got %0d expected 2", acks); end
  endtask

  task automatic test_error();
    do_reset();
    bus.req = 4'b0110; bus.blk = 4'b0110; ramstate = FREE;
    @(negedge CLK); ramstate = ERROR; #1;
    n_tests++;
    if ({owner, bus.rerr, bus.rwait} !== {2'd1, 4'b0010, 4'b1111}) begin
      n_fail++; $display("FAIL err_pulse: got %b expected %b", {owner, bus.rerr, bus.rwait}, {2'd1, 4'b0010, 4'b1111});
    end
    @(negedge CLK); ramstate = FREE; bus.req = 4'b0100; #1;
    n_tests++;
    if ({busy, bus.rerr} !== 5'b0_0000) begin n_fail++; $display("FAIL err_idle: got %b expected 00000", {busy, bus.rerr}); end
    @(negedge CLK); #1;
    n_tests++;
    if ({owner, busy} !== {2'd2, 1'b1}) begin n_fail++; $display("FAIL err_next: got %b expected 101", {owner, busy}); end
  endtask

  task automatic test_drop();
    do_reset();
    bus.req = 4'b1000; bus.blk = 4'b1000; ramstate = ACCESS;
    @(negedge CLK); #1;
    n_tests++;
    if ({owner, bus.rwait} !== {2'd3, 4'b0111}) begin n_fail++; $display("FAIL drop_beat0: got %b expected 110111", {owner, bus.rwait}); end
    @(negedge CLK); bus.req = 4'b0000; #1;
    n_tests++;
    if ({ramREN, ramWEN, bus.rwait, busy} !== {2'b00, 4'b1111, 1'b1}) begin
      n_fail++; $display("FAIL drop_enables: got %b expected 0011111", {ramREN, ramWEN, bus.rwait, busy});
    end
    @(negedge CLK); bus.req = 4'b0001; #1;
    n_tests++;
    if ({busy, bus.rwait} !== 5'b0_1111) begin n_fail++; $display("FAIL drop_idle: got %b expected 01111", {busy, bus.rwait}); end
    @(negedge CLK); #1;
    n_tests++;
    if ({owner, busy} !== {2'd0, 1'b1}) begin n_fail++; $display("FAIL drop_next: got %b expected 001", {owner, busy}); end
  endtask

  task automatic test_reset_mid_xfer();
    logic [1:0] exp_first;
`ifdef ARB_DATA_PRIORITY_EN
    exp_first = 2'd1;
`else
    exp_first = 2'd0;
`endif
    do_reset();
    bus.req = 4'b0100; ramstate = ACCESS;
    @(negedge CLK); #1;
    n_tests++;
    if ({owner, bus.rwait} !== {2'd2, 4'b1011}) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 101011", {owner, bus.rwait}); end
    @(negedge CLK); bus.req = 4'b1000; bus.blk = 4'b1000; ramstate = BUSY;
    @(negedge CLK); #1;
    n_tests++;
    if ({owner, busy, ramREN, ramWEN} !== {2'd3, 3'b110}) begin
      n_fail++; $display("FAIL rstmid_xfer: got %b expected 11110", {owner, busy, ramREN, ramWEN});
    end
    nRST = 1'b0; #1;
    n_tests++;
    if ({busy, ramREN, ramWEN, bus.rwait, bus.rerr} !== 11'b000_1111_0000) begin
      n_fail++; $display("FAIL rstmid_async: got %b expected 00011110000", {busy, ramREN, ramWEN, bus.rwait, bus.rerr});
    end
    bus.req = 4'b1111; bus.blk = 4'b0000;
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK); #1;
    n_tests++;
    if ({owner, busy} !== {exp_first, 1'b1}) begin
      n_fail++; $display("FAIL rstmid_first: got %b expected %b", {owner, busy}, {exp_first, 1'b1});
    end
  endtask

  task automatic test_priority();
    int exp_o [8];
`ifdef ARB_DATA_PRIORITY_EN
    exp_o = '{1, 1, 1, 1, 1, 1, 1, 0};
`else
    exp_o = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    do_reset();
    bus.req = 4'b0011; bus.blk = 4'b0000; ramstate = ACCESS;
    for (int g = 0; g < 8; g++) begin
      if (g != 0) @(negedge CLK);
      @(negedge CLK); #1;
      n_tests++;
      if ({owner, busy, bus.rwait} !== {2'(exp_o[g]), 1'b1, ~(4'b0001 << exp_o[g])}) begin
        n_fail++; $display("FAIL prio_grant%0d: got owner %0d rwait %b expected owner %0d", g, owner, bus.rwait, exp_o[g]);
      end
    end
  endtask

  initial begin
    nRST = 1'b1;
    bus.req = '0; bus.wen = '0; bus.blk = '0; bus.addr = '0; bus.wdata = '0;
    ramstate = FREE; ramload = '0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_write_block();
    test_error();
    test_drop();
    test_reset_mid_xfer();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
